filtr_notch_mc: RTL and testbench
=================================

Name: filtr_notch_mc

Overview:
- Multi-channel second-order IIR notch filter with coefficients programmable at run time. It is the parametrised successor to the fixed-coefficient single-channel notch top.
- One shared multiplier is time-multiplexed over CH channels by a sequencer FSM.
- Coefficient writes land in a shadow bank. The shadow bank is copied to the active bank only when a frame starts, so coefficients never change mid-frame.
- Sits between the sample-rate front end and downstream adaptation/analysis logic.

Parameters:
- DATA_SIZE, 25: sample words are DATA_SIZE-1 bits, signed two's complement.
- COEF_SIZE, 25: coefficient width, signed.
- COEF_FRAC, 23: fractional bits of coefficients; 1.0 = 8388608; range [-2.0, 2.0).
- CH, 4: number of channels (1..16).
- ADDR_W, 4: coefficient address width; must satisfy 2^ADDR_W >= 3*CH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- sample  in  1  frame start strobe; sampled on clk.
- data_in  in  CH*(DATA_SIZE-1)  packed samples; channel c occupies bits [c*(DATA_SIZE-1) +: DATA_SIZE-1].
- coef_we  in  1  shadow coefficient write enable.
- coef_addr  in  ADDR_W  coefficient address = 3*c+k, where k=0 is B1, k=1 is A1, k=2 is A2.
- coef_wdata  in  COEF_SIZE  coefficient value.
- data_out  out  CH*(DATA_SIZE-1)  packed filtered outputs, held between frames.
- filter_done  out  1  one-cycle pulse when data_out is updated.
- busy  out  1  high while a frame is in progress.
- overrun  out  1  sticky flag: a sample strobe arrived while busy.

Behaviour:
- Per-channel equation: y[n] = x[n] + x[n-2] + B1*x[n-1] + A1*y[n-1] + A2*y[n-2].
  - Notch at w0 with pole radius r: B1 = -2cos(w0), A1 = 2r·cos(w0), A2 = -r^2.
- Reset (reset=0, asynchronous):
  - data_out, filter_done, busy, overrun = 0.
  - Delay lines x1, x2, y1, y2 = 0.
  - Shadow and active coefficients = 0.
  - FSM goes to IDLE. A reset mid-frame aborts the frame with no filter_done.
- FSM states: IDLE, CAPT, MUL_B1, MUL_A1, MUL_A2, SUM, DONE.
  - IDLE: sample=1 goes to CAPT. This latches data_in for all channels, copies shadow to active, sets channel index to 0 and sets busy=1.
  - Per channel: MUL_B1 -> MUL_A1 -> MUL_A2 -> SUM, one cycle each.
  - SUM: rounds and saturates the result, writes the data_out slice, shifts x2<=x1, x1<=x, y2<=y1, y1<=y. Then goes to MUL_B1 of the next channel, or to DONE after channel CH-1.
  - DONE: filter_done=1 for exactly one cycle, busy=0, then IDLE.
- Latency: filter_done rises 4*CH+1 rising edges after the edge that accepts sample (17 for CH=4).
  - All data_out slices change during the frame. Consumers read data_out only on filter_done.
  - Frame period is 4*CH+2 cycles; back-to-back sample strobes are accepted from IDLE only.
- sample=1 in any state other than IDLE: ignored, overrun<=1. overrun stays set until reset.
- Arithmetic:
  - Products are full precision, COEF_SIZE+DATA_SIZE-1 bits.
  - Accumulator is COEF_SIZE+DATA_SIZE+2 bits. It is initialised in MUL_B1 with (x + x2) << COEF_FRAC.
  - Rounding: add 2^(COEF_FRAC-1), then arithmetic shift right by COEF_FRAC.
  - Saturation: clamp to [-2^(DATA_SIZE-2), 2^(DATA_SIZE-2)-1].
  - y1/y2 store the saturated value.
- Coefficient writes:
  - Accepted in any state; go to the shadow bank only.
  - coef_addr >= 3*CH is ignored.
  - A write on the same edge as sample acceptance is included in the copy, i.e. it is visible in that frame.

Optional Feature:
- Macro: FILTR_SAT_FLAG_EN.
- Defined: adds input sat_clr (1 bit) and output sat_flag (CH bits).
  - sat_flag[c] is set in SUM when channel c's result was clamped.
  - It is cleared by sat_clr=1 or by reset. Set has priority over clear on the same edge.
- Undefined: neither port exists and no flag logic is generated.

Test Plan:
- Zero coefficients after reset; channel 0 impulse 1000 then zeros over 4 frames -> y = 1000, 0, 1000, 0. filter_done pulses once per frame, exactly 17 edges after accept.
- Channel 1 set to B1=0, A1=0, A2=-4194304 (r^2=0.5); impulse 1000 -> y = 1000, 0, 500, 0, -250, 0, 125. Other channels are unaffected.
- Zero coefficients, channel 2 constant input 8388607 -> y = 8388607 in frames 1, 2 and 3. Frame 3 onward is saturated (unclamped 16777214); with FILTR_SAT_FLAG_EN, sat_flag[2]=1 from frame 3 until sat_clr.
- sample pulsed again 5 cycles after accept -> ignored, overrun=1, frame completes normally, overrun stays 1.
- Write A2 to channel 0 in mid-frame -> current frame uses the old value, the next frame uses the new one. A write on the accept edge takes effect in that same frame.
- Assert reset at cycle 8 of a frame -> outputs and delay lines are 0 and there is no filter_done. The next sample strobe yields an output with no history contribution.

Source files
------------

// File: rtl/filtr_notch_mc.sv
// Multi-channel second-order IIR notch filter; one multiplier shared over CH channels.
// Define FILTR_SAT_FLAG_EN to add per-channel saturation flags (sat_clr / sat_flag).
module filtr_notch_mc #(
  parameter int DATA_SIZE = 25,
  parameter int COEF_SIZE = 25,
  parameter int COEF_FRAC = 23,
  parameter int CH        = 4,
  parameter int ADDR_W    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sample,
  input  logic [CH*(DATA_SIZE-1)-1:0] data_in,
  input  logic                        coef_we,
  input  logic [ADDR_W-1:0]           coef_addr,
  input  logic [COEF_SIZE-1:0]        coef_wdata,
  output logic [CH*(DATA_SIZE-1)-1:0] data_out,
  output logic                        filter_done,
  output logic                        busy,
  output logic                        overrun
`ifdef FILTR_SAT_FLAG_EN
  ,
  input  logic                        sat_clr,
  output logic [CH-1:0]               sat_flag
`endif
);
  localparam int W  = DATA_SIZE - 1;
  localparam int PW = COEF_SIZE + DATA_SIZE - 1;
  localparam int AW = COEF_SIZE + DATA_SIZE + 2;
  localparam int NC = 3 * CH;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int KW = $clog2(NC);
  localparam logic signed [AW-1:0] HALF   = {{(AW-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
  localparam logic signed [AW-1:0] SAT_HI = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0, CAPT = 3'd1, MUL_B1 = 3'd2, MUL_A1 = 3'd3,
    MUL_A2 = 3'd4, SUM = 3'd5, DONE = 3'd6
  } state_t;

  state_t                      state_r, state_s;
  logic                        accept_s, last_s;
  logic [CW-1:0]               ch_r;
  logic [KW-1:0]               kb_s;
  logic signed [COEF_SIZE-1:0] shadow_r [NC];
  logic signed [COEF_SIZE-1:0] active_r [NC];
  logic signed [W-1:0]         xin_r [CH];
  logic signed [W-1:0]         x1_r [CH];
  logic signed [W-1:0]         x2_r [CH];
  logic signed [W-1:0]         y1_r [CH];
  logic signed [W-1:0]         y2_r [CH];
  logic signed [COEF_SIZE-1:0] mc_s;
  logic signed [W-1:0]         md_s;
  logic signed [PW-1:0]        prod_s;
  logic signed [AW-1:0]        acc_r, seed_s, rsum_s, rnd_s;
  logic signed [W-1:0]         y_s;

  // Sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic: three multiply-accumulate cycles plus a write-back per channel
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = sample ? CAPT : IDLE;
      CAPT:    state_s = MUL_B1;
      MUL_B1:  state_s = MUL_A1;
      MUL_A1:  state_s = MUL_A2;
      MUL_A2:  state_s = SUM;
      SUM:     state_s = last_s ? DONE : MUL_B1;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Sequencer control strobes
  always_comb begin
    accept_s = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      IDLE:    accept_s = sample;
      SUM:     last_s   = (ch_r == CW'(CH - 1));
      default: begin
        accept_s = 1'b0;
        last_s   = 1'b0;
      end
    endcase
  end

  // Shared multiplier operand select
  always_comb begin
    kb_s = KW'(int'(ch_r) * 3);
    mc_s = {COEF_SIZE{1'b0}};
    md_s = {W{1'b0}};
    case (state_r)
      MUL_B1: begin
        mc_s = active_r[kb_s];
        md_s = x1_r[ch_r];
      end
      MUL_A1: begin
        mc_s = active_r[kb_s + KW'(2'd1)];
        md_s = y1_r[ch_r];
      end
      MUL_A2: begin
        mc_s = active_r[kb_s + KW'(2'd2)];
        md_s = y2_r[ch_r];
      end
      default: begin
        mc_s = {COEF_SIZE{1'b0}};
        md_s = {W{1'b0}};
      end
    endcase
    prod_s = PW'(mc_s) * PW'(md_s);
  end

  // Accumulator seed, round-half-up and clamp of the channel result
  always_comb begin
    seed_s = (AW'(xin_r[ch_r]) + AW'(x2_r[ch_r])) <<< COEF_FRAC;
    rsum_s = acc_r + HALF;
    rnd_s  = rsum_s >>> COEF_FRAC;
    if (rnd_s > SAT_HI)      y_s = {1'b0, {(W-1){1'b1}}};
    else if (rnd_s < SAT_LO) y_s = {1'b1, {(W-1){1'b0}}};
    else                     y_s = rnd_s[W-1:0];
  end

  // Shadow bank takes writes; active bank snapshots it (plus a same-edge write) on accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NC; i++) begin
        shadow_r[i] <= {COEF_SIZE{1'b0}};
        active_r[i] <= {COEF_SIZE{1'b0}};
      end
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (coef_we && (coef_addr == ADDR_W'(i))) shadow_r[i] <= coef_wdata;
        else                                      shadow_r[i] <= shadow_r[i];
        if (accept_s)
          active_r[i] <= (coef_we && (coef_addr == ADDR_W'(i))) ? coef_wdata : shadow_r[i];
        else
          active_r[i] <= active_r[i];
      end
    end
  end

  // Datapath: input capture, accumulation, write-back and delay-line shift
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_r     <= {CW{1'b0}};
      acc_r    <= {AW{1'b0}};
      data_out <= {(CH*W){1'b0}};
      for (int c = 0; c < CH; c++) begin
        xin_r[c] <= {W{1'b0}};
        x1_r[c]  <= {W{1'b0}};
        x2_r[c]  <= {W{1'b0}};
        y1_r[c]  <= {W{1'b0}};
        y2_r[c]  <= {W{1'b0}};
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            ch_r <= {CW{1'b0}};
            for (int c = 0; c < CH; c++) xin_r[c] <= data_in[c*W +: W];
          end
        end
        MUL_B1:         acc_r <= seed_s + AW'(prod_s);
        MUL_A1, MUL_A2: acc_r <= acc_r + AW'(prod_s);
        SUM: begin
          data_out[int'(ch_r)*W +: W] <= y_s;
          x2_r[ch_r] <= x1_r[ch_r];
          x1_r[ch_r] <= xin_r[ch_r];
          y2_r[ch_r] <= y1_r[ch_r];
          y1_r[ch_r] <= y_s;
          ch_r       <= last_s ? {CW{1'b0}} : ch_r + CW'(1'b1);
        end
        default: ;
      endcase
    end
  end

  // Status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filter_done <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      filter_done <= last_s;
      if (accept_s)    busy <= 1'b1;
      else if (last_s) busy <= 1'b0;
      else             busy <= busy;
      if (sample && (state_r != IDLE)) overrun <= 1'b1;
      else                             overrun <= overrun;
    end
  end

`ifdef FILTR_SAT_FLAG_EN
  logic clamp_s;

  // Clamp indication for the channel being written back
  always_comb begin
    if (state_r == SUM) clamp_s = (rnd_s > SAT_HI) || (rnd_s < SAT_LO);
    else                clamp_s = 1'b0;
  end

  // Sticky per-channel saturation flags; a set beats a same-edge clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_flag <= {CH{1'b0}};
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (clamp_s && (ch_r == CW'(c))) sat_flag[c] <= 1'b1;
        else if (sat_clr)                sat_flag[c] <= 1'b0;
        else                             sat_flag[c] <= sat_flag[c];
      end
    end
  end
`endif

endmodule

// File: tb/tb_filtr_notch_mc.sv
// Directed self-checking bench for filtr_notch_mc (CH=4, 24-bit samples, Q2.23 coefficients).
module tb_filtr_notch_mc;
  localparam int CH = 4;
  localparam int W  = 24;

  localparam int P2_Y1 [9] = '{1000, 0, 500, 0, -250, 0, 125, 0, -62};
  localparam int P3_X  [7] = '{1000, 0, 0, 0, 0, 0, 0};
  localparam int P3_Y  [7] = '{1000, 0, 1000, 0, -500, 0, 500};
  localparam int P3_ACT[7] = '{0, 0, 2, 0, 0, 0, 0};
  localparam logic [6:0] P3_AW = 7'b1000000;
  localparam logic signed [24:0] P3_AD [7] = '{25'sd0, 25'sd0, -25'sd4194304, 25'sd0,
                                               25'sd0, 25'sd0, -25'sd8388608};

  logic            clk = 1'b0;
  logic            reset;
  logic            sample;
  logic [CH*W-1:0] data_in;
  logic            coef_we;
  logic [3:0]      coef_addr;
  logic [24:0]     coef_wdata;
  logic [CH*W-1:0] data_out;
  logic            filter_done;
  logic            busy;
  logic            overrun;
`ifdef FILTR_SAT_FLAG_EN
  logic            sat_clr;
  logic [CH-1:0]   sat_flag;
`endif

  int checks = 0;
  int fails  = 0;

  filtr_notch_mc dut (
    .clk(clk), .reset(reset), .sample(sample), .data_in(data_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .data_out(data_out), .filter_done(filter_done), .busy(busy), .overrun(overrun)
`ifdef FILTR_SAT_FLAG_EN
    , .sat_clr(sat_clr), .sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [CH*W-1:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  function automatic longint out(input int c);
    logic signed [W-1:0] v;
    v = data_out[c*W +: W];
    return longint'(v);
  endfunction

  task automatic wr(input logic [3:0] a, input logic signed [24:0] d);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  // act: 1 = extra sample strobe, 2 = coefficient write (aa/ad), 3 = reset pulse; at act_at
  task automatic frame(input logic [CH*W-1:0] d, input logic aw, input logic [3:0] aa,
                       input logic signed [24:0] ad, input int act_at, input int act);
    int n;
    @(negedge clk);
    data_in = d; sample = 1'b1;
    coef_we = aw; coef_addr = aa; coef_wdata = ad;
    @(posedge clk); #1;
    sample = 1'b0; coef_we = 1'b0; n = 0;
    while (filter_done !== 1'b1 && n < 40) begin
      if (n == act_at) begin
        case (act)
          1: sample = 1'b1;
          2: begin coef_we = 1'b1; coef_addr = aa; coef_wdata = ad; end
          3: reset = 1'b0;
          default: ;
        endcase
      end
      @(posedge clk); #1;
      n++;
      sample = 1'b0; coef_we = 1'b0; reset = 1'b1;
      if (n == 3 && act != 3) check("busy_mid_frame", busy, 1);
    end
    check("done_latency", n, (act == 3) ? 40 : 17);
    if (n < 40) begin
      check("busy_at_done", busy, 0);
      @(posedge clk); #1;
      check("done_one_cycle", filter_done, 0);
    end
  endtask

  initial begin
    reset = 1'b0; sample = 1'b0; data_in = '0;
    coef_we = 1'b0; coef_addr = 4'd0; coef_wdata = 25'd0;
`ifdef FILTR_SAT_FLAG_EN
    sat_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++) check("reset_data_out", out(c), 0);
    check("reset_done", filter_done, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    @(negedge clk);
    reset = 1'b1;

    // Zero coefficients: y = x + x2, impulse on channel 0
    for (int k = 0; k < 4; k++) begin
      frame(pk((k == 0) ? 1000 : 0, 0, 0, 0), 1'b0, 4'd0, 25'sd0, -1, 0);
      check("zero_coef_ch0", out(0), (k % 2 == 0) ? 1000 : 0);
    end

    // Channel 1 A2 = -0.5; channel 2 constant full-scale; extra strobe in frame 3
    wr(4'd5, -25'sd4194304);
    for (int k = 0; k < 9; k++) begin
      frame(pk(0, (k == 0) ? 1000 : 0, 8388607, 0), 1'b0, 4'd0, 25'sd0, 5, (k == 3) ? 1 : 0);
      check("a2_ch1", out(1), P2_Y1[k]);
      check("sat_ch2", out(2), 8388607);
      check("quiet_ch0", out(0), 0);
      check("quiet_ch3", out(3), 0);
      check("overrun_sticky", overrun, (k >= 3) ? 1 : 0);
`ifdef FILTR_SAT_FLAG_EN
      check("sat_flag_ch2", sat_flag[2], (k >= 2) ? 1 : 0);
      check("sat_flag_ch1", sat_flag[1], 0);
`endif
    end
`ifdef FILTR_SAT_FLAG_EN
    @(negedge clk);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    check("sat_flag_clear", sat_flag, 0);
`endif

    // Channel 0 A2 written mid-frame (frame 2) and on the accept edge (frame 6)
    for (int k = 0; k < 7; k++) begin
      frame(pk(P3_X[k], 0, 0, 0), P3_AW[k], 4'd2, P3_AD[k], 8, P3_ACT[k]);
      check("shadow_ch0", out(0), P3_Y[k]);
    end
    check("overrun_held", overrun, 1);

    // Reset at cycle 8 of a frame, then a fresh frame must carry no history
    frame(pk(1000, 0, 0, 0), 1'b0, 4'd0, 25'sd0, -1, 0);
    frame(pk(0, 0, 0, 0), 1'b0, 4'd0, 25'sd0, 8, 3);
    for (int c = 0; c < CH; c++) check("abort_data_out", out(c), 0);
    check("abort_busy", busy, 0);
    check("abort_overrun", overrun, 0);
`ifdef FILTR_SAT_FLAG_EN
    check("abort_sat_flag", sat_flag, 0);
`endif
    frame(pk(5, 0, 0, 0), 1'b0, 4'd0, 25'sd0, -1, 0);
    check("post_reset_ch0", out(0), 5);
    check("post_reset_ch1", out(1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
